// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl - command sequencer behind the UART receiver.
//
// Parses framed byte commands and turns them into register-file writes/reads
// and ALU operations. Results go back to the UART transmit path one byte per
// TX_D_VLD strobe, and only while TX_BUSY is low.
//   0xAA addr data      : register-file write
//   0xBB addr           : register-file read, data byte returned on TX
//   0xCC opA opB fun    : write RF[0]=opA, RF[1]=opB, then run ALU function
//   0xDD fun            : run ALU function on current operands
//   ALU results are returned low byte first, then high byte.
//
// Ports:
//   Clk, RST                 clock; synchronous active-low reset
//   RX_P_DATA, RX_D_VLD      received byte and its one-cycle valid pulse
//   RF_RdData, RF_RdData_VLD register-file read return
//   ALU_OUT, ALU_OUT_VLD     ALU result return
//   TX_BUSY                  transmit path cannot accept a byte
//   RF_Address/WrData/WrEn/RdEn  register-file request (registered)
//   ALU_FUN, ALU_EN          ALU function select and start strobe
//   CLK_GATE_EN              ALU clock enable, high in ALU_FN / ALU_WAIT
//   TX_P_DATA, TX_D_VLD      byte to transmit and its strobe
//
// Build option: define CMD_TIMEOUT_EN to abandon a partial frame after
// TO_CYCLES cycles without a received byte.

module uart_cmd_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int FUN_W     = 4,
    parameter int TO_CYCLES = 4096
) (
    input  logic                  Clk,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_W-1:0]     RF_RdData,
    input  logic                  RF_RdData_VLD,
    input  logic [2*DATA_W-1:0]   ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic                  TX_BUSY,
    output logic [ADDR_W-1:0]     RF_Address,
    output logic [DATA_W-1:0]     RF_WrData,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [FUN_W-1:0]      ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CLK_GATE_EN,
    output logic [DATA_W-1:0]     TX_P_DATA,
    output logic                  TX_D_VLD
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        TX_RD    = 4'd5,
        OP_A     = 4'd6,
        OP_B     = 4'd7,
        ALU_FN   = 4'd8,
        ALU_WAIT = 4'd9,
        TX_LO    = 4'd10,
        TX_HI    = 4'd11
    } state_t;

    state_t               state_r, state_nx;
    logic [ADDR_W-1:0]    wr_addr_r, wr_addr_nx;
    logic [DATA_W-1:0]    rd_data_r, rd_data_nx;
    logic [2*DATA_W-1:0]  result_r, result_nx;

    logic [ADDR_W-1:0]    rf_addr_r, rf_addr_nx;
    logic [DATA_W-1:0]    rf_wdata_r, rf_wdata_nx;
    logic                 rf_wen_r, rf_wen_nx;
    logic                 rf_ren_r, rf_ren_nx;
    logic [FUN_W-1:0]     alu_fun_r, alu_fun_nx;
    logic                 alu_en_r, alu_en_nx;
    logic                 clk_gate_r, clk_gate_nx;
    logic [DATA_W-1:0]    tx_data_r, tx_data_nx;
    logic                 tx_vld_r, tx_vld_nx;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [TO_W-1:0]      to_cnt_r, to_cnt_nx;
    logic                 to_armed_s;
`else
    // TO_CYCLES only matters when the timeout is built in.
    logic                 unused_to_s;
    assign unused_to_s = (TO_CYCLES == 0);
`endif

    // Next-state, latch and registered-output computation.
    always_comb begin
        state_nx    = state_r;
        wr_addr_nx  = wr_addr_r;
        rd_data_nx  = rd_data_r;
        result_nx   = result_r;
        rf_addr_nx  = rf_addr_r;
        rf_wdata_nx = rf_wdata_r;
        rf_wen_nx   = 1'b0;
        rf_ren_nx   = 1'b0;
        alu_fun_nx  = alu_fun_r;
        alu_en_nx   = 1'b0;
        tx_data_nx  = tx_data_r;
        tx_vld_nx   = 1'b0;

        case (state_r)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        8'hAA:   state_nx = WR_ADDR;
                        8'hBB:   state_nx = RD_ADDR;
                        8'hCC:   state_nx = OP_A;
                        8'hDD:   state_nx = ALU_FN;
                        default: state_nx = IDLE;
                    endcase
                end else begin
                    state_nx = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_nx = RX_P_DATA[ADDR_W-1:0];
                    state_nx   = WR_DATA;
                end else begin
                    state_nx = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wen_nx   = 1'b1;
                    rf_addr_nx  = wr_addr_r;
                    rf_wdata_nx = RX_P_DATA;
                    state_nx    = IDLE;
                end else begin
                    state_nx = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_ren_nx  = 1'b1;
                    rf_addr_nx = RX_P_DATA[ADDR_W-1:0];
                    state_nx   = RD_WAIT;
                end else begin
                    state_nx = RD_ADDR;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    rd_data_nx = RF_RdData;
                    state_nx   = TX_RD;
                end else begin
                    state_nx = RD_WAIT;
                end
            end
            TX_RD: begin
                if (!TX_BUSY) begin
                    tx_vld_nx  = 1'b1;
                    tx_data_nx = rd_data_r;
                    state_nx   = IDLE;
                end else begin
                    state_nx = TX_RD;
                end
            end
            OP_A, OP_B: begin
                if (RX_D_VLD) begin
                    rf_wen_nx   = 1'b1;
                    rf_addr_nx  = (state_r == OP_A) ? {ADDR_W{1'b0}} : ADDR_W'(1);
                    rf_wdata_nx = RX_P_DATA;
                    state_nx    = (state_r == OP_A) ? OP_B : ALU_FN;
                end else begin
                    state_nx = state_r;
                end
            end
            ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_en_nx  = 1'b1;
                    alu_fun_nx = RX_P_DATA[FUN_W-1:0];
                    state_nx   = ALU_WAIT;
                end else begin
                    state_nx = ALU_FN;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_nx = ALU_OUT;
                    state_nx  = TX_LO;
                end else begin
                    state_nx = ALU_WAIT;
                end
            end
            TX_LO: begin
                if (!TX_BUSY) begin
                    tx_vld_nx  = 1'b1;
                    tx_data_nx = result_r[DATA_W-1:0];
                    state_nx   = TX_HI;
                end else begin
                    state_nx = TX_LO;
                end
            end
            TX_HI: begin
                if (!TX_BUSY) begin
                    tx_vld_nx  = 1'b1;
                    tx_data_nx = result_r[2*DATA_W-1:DATA_W];
                    state_nx   = IDLE;
                end else begin
                    state_nx = TX_HI;
                end
            end
            default: state_nx = IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // A frame that stalls for TO_CYCLES cycles is abandoned; no byte
        // arrived, so no strobe was set above.
        to_armed_s = state_r inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN};
        if (to_armed_s && !RX_D_VLD && (to_cnt_r == TO_W'(TO_CYCLES - 1))) begin
            state_nx = IDLE;
        end else begin
            state_nx = state_nx;
        end
        if (RX_D_VLD || (state_nx != state_r) || !to_armed_s) begin
            to_cnt_nx = {TO_W{1'b0}};
        end else begin
            to_cnt_nx = to_cnt_r + TO_W'(1);
        end
`endif

        // Registered from the next state so the gate tracks the state exactly
        // and is already open the cycle before ALU_EN can fire.
        clk_gate_nx = (state_nx == ALU_FN) || (state_nx == ALU_WAIT);
    end

    // State, latches and registered outputs.
    always_ff @(posedge Clk) begin
        if (!RST) begin
            state_r    <= IDLE;
            wr_addr_r  <= {ADDR_W{1'b0}};
            rd_data_r  <= {DATA_W{1'b0}};
            result_r   <= {(2*DATA_W){1'b0}};
            rf_addr_r  <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
            rf_wen_r   <= 1'b0;
            rf_ren_r   <= 1'b0;
            alu_fun_r  <= {FUN_W{1'b0}};
            alu_en_r   <= 1'b0;
            clk_gate_r <= 1'b0;
            tx_data_r  <= {DATA_W{1'b0}};
            tx_vld_r   <= 1'b0;
        end else begin
            state_r    <= state_nx;
            wr_addr_r  <= wr_addr_nx;
            rd_data_r  <= rd_data_nx;
            result_r   <= result_nx;
            rf_addr_r  <= rf_addr_nx;
            rf_wdata_r <= rf_wdata_nx;
            rf_wen_r   <= rf_wen_nx;
            rf_ren_r   <= rf_ren_nx;
            alu_fun_r  <= alu_fun_nx;
            alu_en_r   <= alu_en_nx;
            clk_gate_r <= clk_gate_nx;
            tx_data_r  <= tx_data_nx;
            tx_vld_r   <= tx_vld_nx;
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout counter.
    always_ff @(posedge Clk) begin
        if (!RST) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_nx;
        end
    end
`endif

    assign RF_Address  = rf_addr_r;
    assign RF_WrData   = rf_wdata_r;
    assign RF_WrEn     = rf_wen_r;
    assign RF_RdEn     = rf_ren_r;
    assign ALU_FUN     = alu_fun_r;
    assign ALU_EN      = alu_en_r;
    assign CLK_GATE_EN = clk_gate_r;
    assign TX_P_DATA   = tx_data_r;
    assign TX_D_VLD    = tx_vld_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed, table-driven bench for uart_cmd_ctrl. Each table row is one clock
// cycle: inputs applied before the rising edge, registered outputs compared
// after it. Expected values are written by hand from the command protocol.
module tb_uart_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic [15:0] alu_out;
    logic        alu_vld;
    logic        tx_busy;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic        rf_wen;
    logic        rf_ren;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic        clk_gate;
    logic [7:0]  tx_data;
    logic        tx_vld;

    int checks = 0;
    int errors = 0;

    uart_cmd_ctrl #(
        .DATA_W(8), .ADDR_W(4), .FUN_W(4), .TO_CYCLES(16)
    ) dut (
        .Clk(clk), .RST(rst_n),
        .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RF_RdData(rd_data), .RF_RdData_VLD(rd_vld),
        .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld),
        .TX_BUSY(tx_busy),
        .RF_Address(rf_addr), .RF_WrData(rf_wdata),
        .RF_WrEn(rf_wen), .RF_RdEn(rf_ren),
        .ALU_FUN(alu_fun), .ALU_EN(alu_en),
        .CLK_GATE_EN(clk_gate),
        .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst_n;
        logic        rxv;
        logic [7:0]  rxd;
        logic        rdv;
        logic [7:0]  rdd;
        logic        av;
        logic [15:0] ao;
        logic        busy;
        logic [28:0] exp;
    } vec_t;

    vec_t tv[$];

    // Expected output word: {wen, ren, addr, wdata, alu_en, fun, gate, tx_vld, tx_data}
    function automatic logic [28:0] ex(logic wen, logic ren, logic [3:0] addr, logic [7:0] wd,
                                       logic aen, logic [3:0] fun, logic gate, logic txv,
                                       logic [7:0] txd);
        return {wen, ren, addr, wd, aen, fun, gate, txv, txd};
    endfunction

    function automatic void add(string nm, logic rn, logic rxv, logic [7:0] rxd, logic rdv,
                                logic [7:0] rdd, logic av, logic [15:0] ao, logic busy,
                                logic [28:0] e);
        vec_t v;
        v.nm = nm; v.rst_n = rn; v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd;
        v.av = av; v.ao = ao; v.busy = busy; v.exp = e;
        tv.push_back(v);
    endfunction

    function automatic void add_rx(string nm, logic [7:0] b, logic [28:0] e);
        add(nm, 1'b1, 1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, e);
    endfunction

    function automatic void add_idle(string nm, logic [28:0] e);
        add(nm, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, e);
    endfunction

    task automatic cycle(input logic rn, input logic rxv, input logic [7:0] rxd,
                         input logic rdv, input logic [7:0] rdd, input logic av,
                         input logic [15:0] ao, input logic busy);
        @(negedge clk);
        rst_n = rn; rx_vld = rxv; rx_data = rxd; rd_vld = rdv; rd_data = rdd;
        alu_vld = av; alu_out = ao; tx_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm, input logic [28:0] e);
        logic [28:0] act;
        act = {rf_wen, rf_ren, rf_addr, rf_wdata, alu_en, alu_fun, clk_gate, tx_vld, tx_data};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got wen=%b ren=%b addr=%h wd=%h aen=%b fun=%h gate=%b txv=%b txd=%h, want wen=%b ren=%b addr=%h wd=%h aen=%b fun=%h gate=%b txv=%b txd=%h",
                     nm, act[28], act[27], act[26:23], act[22:15], act[14], act[13:10],
                     act[9], act[8], act[7:0], e[28], e[27], e[26:23], e[22:15], e[14],
                     e[13:10], e[9], e[8], e[7:0]);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, e);
        end
    endtask

    initial begin
        logic [28:0] z;
        z = 29'h0;
        rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; rd_vld = 1'b0; rd_data = 8'h00;
        alu_vld = 1'b0; alu_out = 16'h0000; tx_busy = 1'b0;

        // Reset state
        add("reset0", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, z);
        add("reset1", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, z);
        // Write AA,05,3C
        add_rx("wr_cmd",  8'hAA, z);
        add_rx("wr_addr", 8'h05, z);
        add_rx("wr_data", 8'h3C, ex(1'b1, 1'b0, 4'h5, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_idle("wr_done",      ex(1'b0, 1'b0, 4'h5, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        // Read BB,07, data 0x5A three cycles later; a byte in RD_WAIT is dropped
        add_rx("rd_cmd",  8'hBB, ex(1'b0, 1'b0, 4'h5, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_rx("rd_addr", 8'h07, ex(1'b0, 1'b1, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_rx("rd_drop", 8'hAA, ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_idle("rd_wait",      ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add("rd_ret", 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0,
            ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_idle("rd_tx",        ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b1, 8'h5A));
        add_idle("rd_tx_once",   ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h5A));
        add("rdvld_idle", 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 16'h0000, 1'b0,
            ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h5A));
        // ALU with operands CC,12,34,02; result 0x0046 with TX busy for 10 cycles
        add_rx("op_cmd", 8'hCC, ex(1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0, 8'h5A));
        add_rx("op_a",   8'h12, ex(1'b1, 1'b0, 4'h0, 8'h12, 1'b0, 4'h0, 1'b0, 1'b0, 8'h5A));
        add_rx("op_b",   8'h34, ex(1'b1, 1'b0, 4'h1, 8'h34, 1'b0, 4'h0, 1'b1, 1'b0, 8'h5A));
        add_idle("op_gate",     ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h0, 1'b1, 1'b0, 8'h5A));
        add_rx("op_fun", 8'h02, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b1, 4'h2, 1'b1, 1'b0, 8'h5A));
        add_idle("op_wait",     ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b1, 1'b0, 8'h5A));
        add("op_res", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h0046, 1'b1,
            ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b0, 8'h5A));
        for (int i = 0; i < 9; i++) begin
            add("op_busy", 1'b1, (i == 4), 8'hAA, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1,
                ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b0, 8'h5A));
        end
        add_idle("op_tx_lo",    ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b1, 8'h46));
        add_idle("op_tx_hi",    ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b1, 8'h00));
        add_idle("op_done",     ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b0, 8'h00));
        // ALU_OUT_VLD in IDLE ignored; unknown opcode 77; then DD,01 -> FFFE
        add("aluvld_idle", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0,
            ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b0, 8'h00));
        add_rx("unk_77", 8'h77, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b0, 1'b0, 8'h00));
        add_rx("fn_cmd", 8'hDD, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h2, 1'b1, 1'b0, 8'h00));
        add_rx("fn_fun", 8'h01, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b1, 4'h1, 1'b1, 1'b0, 8'h00));
        add("fn_res", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'hFFFE, 1'b0,
            ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b0, 8'h00));
        add_idle("fn_tx_lo",    ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b1, 8'hFE));
        add_idle("fn_tx_hi",    ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b1, 8'hFF));
        add_idle("fn_done",     ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b0, 8'hFF));
        // Reset mid-frame: AA,03, RST=0, then 3C is ignored in IDLE
        add_rx("rm_cmd",  8'hAA, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b0, 8'hFF));
        add_rx("rm_addr", 8'h03, ex(1'b0, 1'b0, 4'h1, 8'h34, 1'b0, 4'h1, 1'b0, 1'b0, 8'hFF));
        add("rm_reset", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, z);
        add_rx("rm_3c",   8'h3C, z);
        add_idle("rm_idle", z);
        // IDLE still parses a fresh frame after the reset
        add_rx("rw_cmd",  8'hAA, z);
        add_rx("rw_addr", 8'h06, z);
        add_rx("rw_data", 8'h11, ex(1'b1, 1'b0, 4'h6, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        add_idle("rw_done",      ex(1'b0, 1'b0, 4'h6, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));

        foreach (tv[i]) begin
            cycle(tv[i].rst_n, tv[i].rxv, tv[i].rxd, tv[i].rdv, tv[i].rdd,
                  tv[i].av, tv[i].ao, tv[i].busy);
            check_all(tv[i].nm, tv[i].exp);
        end

        // Stalled frame: AA, 16 quiet cycles, then 09, 11
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            check1("stall_no_wen", rf_wen, 1'b0);
        end
        cycle(1'b1, 1'b1, 8'h09, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
`ifdef CMD_TIMEOUT_EN
        check_all("to_bytes_ignored", ex(1'b0, 1'b0, 4'h6, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
        // Timeout in ALU_FN also closes the clock gate
        cycle(1'b1, 1'b1, 8'hDD, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        check_all("to_gate_on", ex(1'b0, 1'b0, 4'h6, 8'h11, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00));
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            check1("to_gate_hold", clk_gate, 1'b1);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        check1("to_gate_drop", clk_gate, 1'b0);
`else
        check_all("stall_completes", ex(1'b1, 1'b0, 4'h9, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer behind the UART receiver. Parses framed byte commands from RX_P_DATA/RX_D_VLD and drives register-file writes and reads and ALU operations. Returns results to the UART transmit path through a busy-gated valid strobe, and gates the ALU clock while an operation is pending.

Parameters:
DATA_W, 8, byte width of RX/TX/register-file data
ADDR_W, 4, register-file address width
FUN_W, 4, ALU function code width
TO_CYCLES, 4096, inter-byte timeout in Clk cycles (used only with CMD_TIMEOUT_EN)

Ports:
Clk  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-low reset, sampled on rising edge of Clk
RX_P_DATA  input  DATA_W  received byte from UART RX
RX_D_VLD  input  1  one-cycle pulse, RX_P_DATA valid
RF_RdData  input  DATA_W  register-file read data
RF_RdData_VLD  input  1  pulse, RF_RdData valid
ALU_OUT  input  2*DATA_W  ALU result
ALU_OUT_VLD  input  1  pulse, ALU_OUT valid
TX_BUSY  input  1  transmit path cannot accept a byte
RF_Address  output  ADDR_W  register-file address
RF_WrData  output  DATA_W  register-file write data
RF_WrEn  output  1  one-cycle write strobe
RF_RdEn  output  1  one-cycle read strobe
ALU_FUN  output  FUN_W  ALU function select
ALU_EN  output  1  one-cycle ALU start strobe
CLK_GATE_EN  output  1  ALU clock enable
TX_P_DATA  output  DATA_W  byte to transmit
TX_D_VLD  output  1  one-cycle transmit strobe

Behaviour:
- Single clock domain, Clk. Reset is synchronous and active-low: RST is sampled on the rising edge of Clk. While RST=0, state goes to IDLE and every output and internal latch clears to 0.
- All outputs are registered. A strobe caused by input event X is high in the cycle after X.
- States and transitions (all "on byte" means on RX_D_VLD=1):
- IDLE:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to OP_A.
  - 0xDD goes to ALU_FN.
  - Any other byte is ignored; state stays IDLE.
- WR_ADDR: on byte, latch byte[ADDR_W-1:0], go to WR_DATA.
- WR_DATA: on byte, pulse RF_WrEn with RF_Address=latched address and RF_WrData=byte, go to IDLE.
- RD_ADDR: on byte, pulse RF_RdEn with RF_Address=byte[ADDR_W-1:0], go to RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, latch RF_RdData, go to TX_RD.
- TX_RD: when TX_BUSY=0, pulse TX_D_VLD with the latched byte, go to IDLE. While TX_BUSY=1, hold state.
- OP_A: on byte, write it to RF address 0 (RF_WrEn pulse), go to OP_B.
- OP_B: on byte, write it to RF address 1, go to ALU_FN.
- ALU_FN: on byte, pulse ALU_EN with ALU_FUN=byte[FUN_W-1:0], go to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT, go to TX_LO.
- TX_LO: when TX_BUSY=0, pulse TX_D_VLD with result[DATA_W-1:0], go to TX_HI.
- TX_HI: when TX_BUSY=0, pulse TX_D_VLD with result[2*DATA_W-1:DATA_W], go to IDLE.
- CLK_GATE_EN=1 exactly while state is ALU_FN or ALU_WAIT, registered. It is therefore high from the cycle after entering ALU_FN, and that is at least one cycle before ALU_EN.
- RF_Address, RF_WrData and ALU_FUN hold their last driven value between strobes.
- TX_P_DATA holds its value until the next TX_D_VLD.
- Boundary conditions:
  - RX_D_VLD in RD_WAIT, ALU_WAIT, TX_RD, TX_LO or TX_HI: the byte is dropped, with no state change.
  - RF_RdData_VLD outside RD_WAIT, or ALU_OUT_VLD outside ALU_WAIT: ignored.
  - TX_BUSY stuck high: hold the TX state indefinitely; no strobe is ever issued while TX_BUSY=1.
  - A response byte never changes while the state is waiting on TX_BUSY.
  - RST=0 mid-frame: the frame is abandoned and no strobe is issued in the reset cycle.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FN, and clears on every RX_D_VLD and on every state change.
  - When the counter reaches TO_CYCLES-1 with no byte received, state returns to IDLE the next cycle. No strobe is issued, and CLK_GATE_EN drops.
- Undefined: no counter exists; a partial frame waits forever.

Test Plan:
- Write: bytes AA,05,3C -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C; state returns to IDLE.
- Read: bytes BB,07; RF_RdData=0x5A returned 3 cycles later; TX_BUSY=0 -> RF_RdEn with addr 7, then exactly one TX_D_VLD with TX_P_DATA=0x5A.
- ALU with operands: bytes CC,12,34,02; ALU_OUT=0x0046; TX_BUSY high for 10 cycles when the result arrives ->
  - RF writes to addr0=0x12 and addr1=0x34.
  - ALU_EN with ALU_FUN=2, with CLK_GATE_EN high beforehand.
  - TX bytes 0x46 then 0x00, both issued only after TX_BUSY falls.
- Unknown opcode 0x77, then DD,01; ALU_OUT=0xFFFE -> 0x77 has no effect; ALU_EN with FUN=1; TX bytes FE then FF.
- Reset mid-frame: AA,03, then RST=0 for one cycle, then 3C -> no RF_WrEn; all outputs are 0 during the reset cycle; 3C is ignored in IDLE.
- With CMD_TIMEOUT_EN and TO_CYCLES=16: byte AA, then 16 idle cycles, then 09,11 -> return to IDLE after 16 cycles; no RF_WrEn; bytes 09 and 11 are ignored.
